coffee_vend_controller: RTL and testbench
=========================================

Name: coffee_vend_controller

Overview:
- Parametrised single-clock vending controller that replaces the discrete coin counter, coin comparator, subtractor, general timer, per-coffee timer and ingredient FSM with one block.
- Accumulates credit from coin pulses with saturation and rejection, prices the selected recipe, and returns change.
- Sequences ingredient valves from a per-recipe duration table, using an internal seconds tick.
- Supports cancel/refund and reports credit for the existing 7-segment display modules.

Parameters:
- N_RECIPES, 4, number of selectable recipes; sel width is $clog2(N_RECIPES).
- N_ING, 5, number of ingredient outputs, in order: water, coffee, sugar, milk, chocolate.
- CREDIT_W, 4, width of credit, price and change, in units of 100.
- MAX_CREDIT, 10, maximum credit held (1000).
- STEP_W, 2, width of the per-ingredient duration field, in seconds.
- TICKS_PER_SEC, 50_000_000, clock cycles per second.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- coin_100  in  1  one-cycle pulse; adds 1 unit
- coin_500  in  1  one-cycle pulse; adds 5 units
- sel  in  $clog2(N_RECIPES)  recipe index, sampled on confirm
- confirm  in  1  one-cycle pulse; request vend
- cancel  in  1  one-cycle pulse; request refund
- credit  out  CREDIT_W  current credit
- change  out  CREDIT_W  change or refund value, held until the next vend or refund
- change_valid  out  1  one-cycle pulse when change is updated
- ingredient  out  N_ING  one-hot valve enables, all 0 when idle
- busy  out  1  high in DISPENSE and DONE
- finished  out  1  one-cycle pulse at the end of a vend
- coin_reject  out  1  one-cycle pulse when a coin is not accepted
- insufficient  out  1  one-cycle pulse when confirm arrives with too little credit

Behaviour:
- Reset, synchronous, takes priority over everything, including mid-dispense:
  - state goes to IDLE;
  - credit, change and the tick counter go to 0;
  - every output goes to 0.
- States are IDLE, DISPENSE and DONE.
- IDLE, coins:
  - inc = coin_100 + 5*coin_500, so both pulses together give 6.
  - If credit + inc <= MAX_CREDIT, credit updates next cycle.
  - Otherwise credit is unchanged and coin_reject pulses. The whole inc is rejected, never a partial add.
- IDLE, event priority in one cycle: cancel, then confirm, then coins. A coin in the same cycle as cancel or confirm is rejected.
- IDLE, cancel:
  - change <= credit, credit <= 0, and change_valid pulses.
  - This also happens with credit 0, which gives change 0.
- IDLE, confirm:
  - If credit >= PRICE[sel]: latch sel; change <= credit - PRICE[sel]; credit <= 0; step <= 0; go to DISPENSE.
  - Otherwise insufficient pulses and credit is unchanged.
- DISPENSE:
  - step i lasts DUR[sel][i]*TICKS_PER_SEC cycles with ingredient = 1<<i.
  - A step whose duration is 0 takes exactly 1 cycle with ingredient = 0.
  - The tick counter restarts at every step entry.
  - The first valve asserts on the cycle after confirm is sampled.
  - After step N_ING-1 the block goes to DONE.
- DISPENSE, other inputs: coins are rejected with coin_reject; confirm and cancel are ignored (no pulse, no effect).
- DONE lasts 1 cycle: finished and change_valid pulse, ingredient = 0, then back to IDLE.
- All outputs are registered.
- Credit arithmetic uses a CREDIT_W+3 bit intermediate, so there is no wrap.
- Elaboration asserts that MAX_CREDIT < 2**CREDIT_W and that every PRICE <= MAX_CREDIT.

Decomposition:
- Package coffee_vend_pkg holds:
  - the state enum;
  - ingredient index constants;
  - PRICE table: espresso 5, americano 6, latte 8, mocha 9;
  - DUR table, in order water/coffee/sugar/milk/chocolate:
    - espresso {1,2,0,0,0}
    - americano {3,1,1,0,0}
    - latte {1,1,1,2,0}
    - mocha {1,1,1,1,2}
- One sub-module, step_timer:
  - takes load, a duration and TICKS_PER_SEC;
  - outputs done, which asserts after duration*TICKS_PER_SEC cycles, or after 1 cycle when duration is 0.

Test Plan (TICKS_PER_SEC=4):
- coin_500, coin_100, coin_500 on separate cycles -> credit 5, 6, then 6 again with coin_reject (11 > 10); then coin_100 four times -> credit 10.
- Credit 10, sel=2, confirm -> change 2, credit 0, busy=1. Valves run water 4 cycles, coffee 4, sugar 4, milk 8, chocolate 1 idle cycle. Then finished and change_valid pulse; total 21 cycles after the vend begins.
- Credit 8, sel=3, confirm -> insufficient pulses, credit stays 8. Then cancel -> change 8, credit 0, change_valid pulses.
- During espresso DISPENSE, pulse coin_500, confirm and cancel -> coin_reject pulses, credit stays 0, valve sequence unchanged: water 4, coffee 8, then 3 idle cycles.
- Reset asserted during the coffee step of americano -> next cycle ingredient=0, busy=0, credit=0, change=0.
- confirm and coin_100 in the same cycle with credit 6, sel=1 -> vend starts, change 0, coin_reject pulses.

Source files
------------

// File: rtl/coffee_vend_pkg.sv
// Shared constants for the coffee vending controller: state encoding,
// ingredient ordering, and the per-recipe price and duration tables.
package coffee_vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  // Valve order; ING_COUNT is the number of valves the tables describe.
  typedef enum int {
    ING_WATER,
    ING_COFFEE,
    ING_SUGAR,
    ING_MILK,
    ING_CHOC,
    ING_COUNT
  } ing_e;

  localparam int N_TBL_RECIPES = 4;

  // Prices in units of 100: espresso, americano, latte, mocha.
  localparam int PRICE [N_TBL_RECIPES] = '{5, 6, 8, 9};

  // Seconds per valve, in order water/coffee/sugar/milk/chocolate.
  localparam int DUR [N_TBL_RECIPES][ING_COUNT] = '{
    '{1, 2, 0, 0, 0},
    '{3, 1, 1, 0, 0},
    '{1, 1, 1, 2, 0},
    '{1, 1, 1, 1, 2}
  };

endpackage

// File: rtl/coffee_vend_controller_step_timer.sv
// Per-step down-counter. Loading a duration of d seconds makes done assert
// on the d*TICKS_PER_SEC-th cycle after the load; a zero duration gives a
// single-cycle step.
module step_timer #(
  parameter int STEP_W        = 2,
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [STEP_W-1:0] duration,
  output logic              done
);

  localparam int MAX_TICKS = ((2 ** STEP_W) - 1) * TICKS_PER_SEC;
  localparam int CNT_W     = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  // Counter starts at length-1 so terminal count marks the step's last cycle.
  always_comb begin
    load_val = '0;
    if (duration != '0)
      load_val = CNT_W'(duration) * CNT_W'(TICKS_PER_SEC) - CNT_W'(1);
  end

  // Down-count, reloaded at every step entry and parked at zero.
  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/coffee_vend_controller.sv
// Coffee vending controller: coin credit with saturation/rejection, recipe
// pricing and change, timed ingredient valve sequencing, cancel/refund.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | accepting coins, cancel and confirm
//  DISPENSE | stepping through valves of the latched recipe
//  DONE     | one cycle: finished and change_valid pulse
module coffee_vend_controller
  import coffee_vend_pkg::*;
#(
  parameter int N_RECIPES     = 4,
  parameter int N_ING         = 5,
  parameter int CREDIT_W      = 4,
  parameter int MAX_CREDIT    = 10,
  parameter int STEP_W        = 2,
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         coin_100,
  input  logic                         coin_500,
  input  logic [$clog2(N_RECIPES)-1:0] sel,
  input  logic                         confirm,
  input  logic                         cancel,
  output logic [CREDIT_W-1:0]          credit,
  output logic [CREDIT_W-1:0]          change,
  output logic                         change_valid,
  output logic [N_ING-1:0]             ingredient,
  output logic                         busy,
  output logic                         finished,
  output logic                         coin_reject,
  output logic                         insufficient
);

  localparam int SEL_W = $clog2(N_RECIPES);
  localparam int IDX_W = $clog2(N_ING);
  localparam int AW    = CREDIT_W + 3;

  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] DISPENSE = ST_DISPENSE;
  localparam logic [1:0] DONE     = ST_DONE;

  if (MAX_CREDIT >= 2 ** CREDIT_W) begin : g_bad_max_credit
    $fatal(1, "MAX_CREDIT does not fit in CREDIT_W bits");
  end
  if (N_ING != ING_COUNT) begin : g_bad_n_ing
    $fatal(1, "N_ING must match the duration table");
  end
  if (N_RECIPES > N_TBL_RECIPES) begin : g_bad_n_recipes
    $fatal(1, "N_RECIPES exceeds the recipe tables");
  end
  for (genvar r = 0; r < N_RECIPES; r++) begin : g_price_chk
    if (PRICE[r] > MAX_CREDIT) begin : g_bad_price
      $fatal(1, "recipe price above MAX_CREDIT");
    end
  end

  logic [1:0]        state;
  logic [SEL_W-1:0]  sel_q;
  logic [IDX_W-1:0]  step;

  logic [AW-1:0]     credit_ext, inc, coin_sum, price_ext;
  logic              coin_any, vend_ok, last_step, timer_done, timer_load;
  logic [SEL_W-1:0]  nxt_sel;
  logic [IDX_W-1:0]  nxt_idx;
  logic [STEP_W-1:0] nxt_dur;
  logic [N_ING-1:0]  nxt_valve;

  // Credit arithmetic in a widened domain, plus the duration/valve of the
  // step about to be entered (first step from IDLE, next step otherwise).
  always_comb begin
    credit_ext = AW'(credit);
    inc        = AW'(coin_100) + (coin_500 ? AW'(5) : '0);
    coin_sum   = credit_ext + inc;
    price_ext  = AW'(PRICE[sel]);
    coin_any   = coin_100 | coin_500;
    vend_ok    = (state == IDLE) && !cancel && confirm && (credit_ext >= price_ext);
    last_step  = (step == IDX_W'(N_ING - 1));
    nxt_sel    = sel_q;
    nxt_idx    = step + 1'b1;
    if (state == IDLE) begin
      nxt_sel = sel;
      nxt_idx = IDX_W'(ING_WATER);
    end
    nxt_dur    = STEP_W'(DUR[nxt_sel][nxt_idx]);
    nxt_valve  = (nxt_dur != '0) ? (N_ING'(1) << nxt_idx) : '0;
    timer_load = vend_ok || ((state == DISPENSE) && timer_done && !last_step);
  end

  step_timer #(
    .STEP_W        (STEP_W),
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_step_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .duration (nxt_dur),
    .done     (timer_done)
  );

  // Main FSM; every output is a register, pulses default low each cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sel_q        <= '0;
      step         <= '0;
      credit       <= '0;
      change       <= '0;
      change_valid <= 1'b0;
      ingredient   <= '0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      change_valid <= 1'b0;
      finished     <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel) begin
            change       <= credit;
            credit       <= '0;
            change_valid <= 1'b1;
            coin_reject  <= coin_any;
          end else if (confirm) begin
            coin_reject <= coin_any;
            if (vend_ok) begin
              sel_q      <= sel;
              step       <= '0;
              change     <= CREDIT_W'(credit_ext - price_ext);
              credit     <= '0;
              busy       <= 1'b1;
              ingredient <= nxt_valve;
              state      <= DISPENSE;
            end else begin
              insufficient <= 1'b1;
            end
          end else if (coin_any) begin
            if (coin_sum <= AW'(MAX_CREDIT))
              credit <= CREDIT_W'(coin_sum);
            else
              coin_reject <= 1'b1;
          end
        end
        DISPENSE: begin
          coin_reject <= coin_any;
          if (timer_done) begin
            if (last_step) begin
              ingredient   <= '0;
              finished     <= 1'b1;
              change_valid <= 1'b1;
              state        <= DONE;
            end else begin
              step       <= nxt_idx;
              ingredient <= nxt_valve;
            end
          end
        end
        DONE: begin
          coin_reject <= coin_any;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy       <= 1'b0;
          ingredient <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coffee_vend_controller.sv
// Self-checking bench for coffee_vend_controller with a fast seconds tick.
module tb_coffee_vend_controller;

  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       coin_100 = 1'b0, coin_500 = 1'b0, confirm = 1'b0, cancel = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] credit, change;
  logic       change_valid, busy, finished, coin_reject, insufficient;
  logic [4:0] ingredient;

  int errors = 0;
  int checks = 0;
  int m_credit = 0;
  int m_change = 0;

  int price_tbl [4] = '{5, 6, 8, 9};
  int dur_tbl [4][5] = '{'{1, 2, 0, 0, 0}, '{3, 1, 1, 0, 0},
                         '{1, 1, 1, 2, 0}, '{1, 1, 1, 1, 2}};

  coffee_vend_controller #(
    .N_RECIPES(4), .N_ING(5), .CREDIT_W(4), .MAX_CREDIT(10),
    .STEP_W(2), .TICKS_PER_SEC(T)
  ) dut (
    .clock(clock), .reset(reset), .coin_100(coin_100), .coin_500(coin_500),
    .sel(sel), .confirm(confirm), .cancel(cancel), .credit(credit),
    .change(change), .change_valid(change_valid), .ingredient(ingredient),
    .busy(busy), .finished(finished), .coin_reject(coin_reject),
    .insufficient(insufficient)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One IDLE cycle: drive inputs for one edge, then compare against the model.
  task automatic idle_cycle(input logic c1, input logic c5, input logic cf,
                            input logic cn, input logic [1:0] s);
    int inc;
    logic e_rej, e_ins, e_cv;
    coin_100 = c1; coin_500 = c5; confirm = cf; cancel = cn; sel = s;
    tick();
    coin_100 = 0; coin_500 = 0; confirm = 0; cancel = 0;
    inc = int'(c1) + 5 * int'(c5);
    e_rej = 0; e_ins = 0; e_cv = 0;
    if (cn) begin
      m_change = m_credit; m_credit = 0; e_cv = 1; e_rej = (inc != 0);
    end else if (cf) begin
      e_ins = (m_credit < price_tbl[s]); e_rej = (inc != 0);
    end else if (inc != 0) begin
      if (m_credit + inc <= 10) m_credit = m_credit + inc;
      else e_rej = 1;
    end
    checks++; if (credit !== 4'(m_credit)) begin errors++; $display("FAIL idle_credit got=%0d exp=%0d", credit, m_credit); end
    checks++; if (change !== 4'(m_change)) begin errors++; $display("FAIL idle_change got=%0d exp=%0d", change, m_change); end
    checks++; if (coin_reject !== e_rej) begin errors++; $display("FAIL idle_coin_reject got=%b exp=%b", coin_reject, e_rej); end
    checks++; if (insufficient !== e_ins) begin errors++; $display("FAIL idle_insufficient got=%b exp=%b", insufficient, e_ins); end
    checks++; if (change_valid !== e_cv) begin errors++; $display("FAIL idle_change_valid got=%b exp=%b", change_valid, e_cv); end
    checks++; if ({busy, finished, ingredient} !== 7'b0) begin errors++; $display("FAIL idle_quiet got busy=%b fin=%b ing=%b exp 0", busy, finished, ingredient); end
  endtask

  // Full vend: expected valve trace built per cycle from the recipe tables.
  // inj >= 0 pulses coin_500/confirm/cancel together after trace cycle inj.
  task automatic run_vend(input logic [1:0] s, input logic c1, input logic c5, input int inj);
    logic [4:0] q[$];
    int exp_ch;
    logic e_rej;
    for (int i = 0; i < 5; i++) begin
      if (dur_tbl[s][i] == 0) q.push_back(5'b0);
      else for (int j = 0; j < dur_tbl[s][i] * T; j++) q.push_back(5'(1 << i));
    end
    exp_ch = m_credit - price_tbl[s];
    m_credit = 0; m_change = exp_ch;
    sel = s; confirm = 1; coin_100 = c1; coin_500 = c5;
    tick();
    confirm = 0; coin_100 = 0; coin_500 = 0;
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) begin
        tick();
        coin_500 = 0; confirm = 0; cancel = 0;
      end
      e_rej = (k == 0) ? (c1 | c5) : (k == inj + 1);
      checks++; if (ingredient !== q[k]) begin errors++; $display("FAIL vend_ingredient sel=%0d k=%0d got=%b exp=%b", s, k, ingredient, q[k]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vend_busy k=%0d got=%b exp=1", k, busy); end
      checks++; if (credit !== 4'd0) begin errors++; $display("FAIL vend_credit k=%0d got=%0d exp=0", k, credit); end
      checks++; if (change !== 4'(exp_ch)) begin errors++; $display("FAIL vend_change k=%0d got=%0d exp=%0d", k, change, exp_ch); end
      checks++; if (finished !== 1'b0) begin errors++; $display("FAIL vend_finished_early k=%0d got=%b exp=0", k, finished); end
      checks++; if (coin_reject !== e_rej) begin errors++; $display("FAIL vend_coin_reject k=%0d got=%b exp=%b", k, coin_reject, e_rej); end
      checks++; if (insufficient !== 1'b0) begin errors++; $display("FAIL vend_insufficient k=%0d got=%b exp=0", k, insufficient); end
      if (k > 0) begin
        checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL vend_change_valid k=%0d got=%b exp=0", k, change_valid); end
      end
      if (k == inj) begin coin_500 = 1; confirm = 1; cancel = 1; end
    end
    tick();
    coin_500 = 0; confirm = 0; cancel = 0;
    checks++; if ({finished, change_valid, busy} !== 3'b111) begin errors++; $display("FAIL done_pulses got fin=%b cv=%b busy=%b exp 111", finished, change_valid, busy); end
    checks++; if (ingredient !== 5'b0) begin errors++; $display("FAIL done_ingredient got=%b exp=0", ingredient); end
    checks++; if (change !== 4'(exp_ch)) begin errors++; $display("FAIL done_change got=%0d exp=%0d", change, exp_ch); end
    tick();
    checks++; if ({finished, change_valid, busy} !== 3'b000) begin errors++; $display("FAIL after_done got fin=%b cv=%b busy=%b exp 000", finished, change_valid, busy); end
  endtask

  task automatic test_reset();
    reset = 1; coin_500 = 1; confirm = 1;
    tick(); tick();
    reset = 0; coin_500 = 0; confirm = 0;
    m_credit = 0; m_change = 0;
    checks++; if ({credit, change} !== 8'b0) begin errors++; $display("FAIL reset_credit_change got=%0d/%0d exp 0/0", credit, change); end
    checks++; if ({change_valid, ingredient, busy, finished, coin_reject, insufficient} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got cv=%b ing=%b busy=%b fin=%b rej=%b ins=%b exp 0", change_valid, ingredient, busy, finished, coin_reject, insufficient);
    end
  endtask

  task automatic test_coins();
    idle_cycle(0, 1, 0, 0, 0);
    idle_cycle(1, 0, 0, 0, 0);
    idle_cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle_cycle(1, 0, 0, 0, 0);
    idle_cycle(1, 0, 0, 0, 0);
  endtask

  task automatic test_vend_latte();
    run_vend(2'd2, 0, 0, -1);
  endtask

  task automatic test_insufficient_cancel();
    idle_cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle_cycle(1, 0, 0, 0, 0);
    idle_cycle(0, 0, 1, 0, 2'd3);
    idle_cycle(0, 0, 0, 1, 0);
    idle_cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_dispense_ignore();
    idle_cycle(0, 1, 0, 0, 0);
    run_vend(2'd0, 0, 0, 2);
  endtask

  task automatic test_reset_mid_dispense();
    idle_cycle(1, 1, 0, 0, 0);
    sel = 2'd1; confirm = 1;
    tick();
    confirm = 0;
    for (int k = 1; k <= 13; k++) tick();
    checks++; if (ingredient !== 5'b00010) begin errors++; $display("FAIL mid_coffee_step got=%b exp=00010", ingredient); end
    reset = 1;
    tick();
    reset = 0;
    m_credit = 0; m_change = 0;
    checks++; if ({ingredient, busy} !== 6'b0) begin errors++; $display("FAIL mid_reset_ing_busy got ing=%b busy=%b exp 0", ingredient, busy); end
    checks++; if ({credit, change} !== 8'b0) begin errors++; $display("FAIL mid_reset_credit_change got=%0d/%0d exp 0/0", credit, change); end
    idle_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_confirm_with_coin();
    idle_cycle(0, 1, 0, 0, 0);
    idle_cycle(1, 0, 0, 0, 0);
    run_vend(2'd1, 1, 0, -1);
  endtask

  task automatic test_random();
    int r;
    logic [1:0] s;
    logic c1, c5, cf;
    for (int n = 0; n < 250; n++) begin
      r  = int'($urandom_range(0, 99));
      s  = 2'($urandom_range(0, 3));
      c1 = 1'($urandom_range(0, 1));
      c5 = ($urandom_range(0, 3) == 0);
      cf = 1'($urandom_range(0, 1));
      if (r < 8) idle_cycle(c1, c5, cf, 1, s);
      else if (r < 22) begin
        if (m_credit >= price_tbl[s]) run_vend(s, c1, c5, ($urandom_range(0, 2) == 0) ? 1 : -1);
        else idle_cycle(c1, c5, 1, 0, s);
      end else idle_cycle(c1, c5, 0, 0, s);
    end
  endtask

  initial begin
    test_reset();
    test_coins();
    test_vend_latte();
    test_insufficient_cancel();
    test_dispense_ignore();
    test_reset_mid_dispense();
    test_confirm_with_coin();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
